// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the multi-cycle ALU and the control unit that
// drives it: op-code encodings and the ALU sequencing state type.
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_DIV = 4'b1010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } alu_state_e;

    // True for the ops that run over several clocks.
    function automatic logic is_iterative(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq
// Iterative datapath shared by MUL (shift-add, shift right) and DIV
// (restoring, one quotient bit per clock).
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   go           latch a/b/is_div and start iterating on the next edges
//   is_div       1 = divide a by b, 0 = multiply a by b
//   a, b         operands (a = dividend / multiplicand, b = divisor / multiplier)
//   fin          high in the cycle whose closing edge completes the op
//   hi, lo       result valid while fin is high (product halves or rem/quot)
module alu_muldiv_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             fin,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic             active_q;
    logic             div_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] opnd_q;    // multiplicand or divisor
    logic [WIDTH-1:0] acc_hi_q;  // partial product high half / remainder
    logic [WIDTH-1:0] acc_lo_q;  // multiplier bits / dividend -> quotient

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_trial;
    logic             div_ge;
    logic             div_by_zero;
    logic             last;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    always_comb begin
        // MUL: add multiplicand into the high half when the current
        // multiplier bit is set, then shift {carry,hi,lo} right by one.
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
        // DIV: shift the next dividend bit into the remainder and subtract
        // the divisor only when it fits (restoring step).
        div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd_q});
        div_trial = div_shift[WIDTH-1:0] - opnd_q;

        if (div_q) begin
            step_hi = div_ge ? div_trial : div_shift[WIDTH-1:0];
            step_lo = {acc_lo_q[WIDTH-2:0], div_ge};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end

        last        = (cnt_q == CNT_W'(WIDTH - 1));
        div_by_zero = div_q && (opnd_q == '0);
        fin         = active_q && (last || div_by_zero);

        // Divide by zero finishes on the first iteration cycle, before any
        // shifting, so acc_lo_q still holds the dividend.
        if (div_by_zero) begin
            hi = acc_lo_q;
            lo = '1;
        end else begin
            hi = step_hi;
            lo = step_lo;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            div_q    <= 1'b0;
            cnt_q    <= '0;
            opnd_q   <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
        end else if (go) begin
            active_q <= 1'b1;
            div_q    <= is_div;
            cnt_q    <= '0;
            opnd_q   <= is_div ? b : a;
            acc_hi_q <= '0;
            acc_lo_q <= is_div ? a : b;
        end else if (active_q) begin
            acc_hi_q <= step_hi;
            acc_lo_q <= step_lo;
            if (fin) begin
                active_q <= 1'b0;
                cnt_q    <= '0;
            end else begin
                cnt_q    <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/alu_multiciclo.sv
// alu_multiciclo
// Multi-cycle EX-stage ALU. Logic/add/sub/compare complete in one clock;
// MUL and DIV iterate over WIDTH clocks in alu_muldiv_seq and load HI/LO.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             request, sampled only while busy=0
//   selector          op code (see alu_pkg)
//   Data1, Data2      operands A and B
//   salida            registered result, held until the next done
//   hi, lo            MUL product halves / DIV remainder and quotient
//   busy              iterative op in progress
//   done              one-cycle pulse when salida (and hi/lo) update
//   zero, overflow    registered flags, updated with done
module alu_multiciclo
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       selector,
    input  logic [WIDTH-1:0] Data1,
    input  logic [WIDTH-1:0] Data2,
    output logic [WIDTH-1:0] salida,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             zero,
    output logic             overflow
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam int unsigned MSB   = WIDTH - 1;

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] salida_q, salida_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] add_res;
    logic [WIDTH-1:0] sub_res;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;

    logic             seq_go;
    logic             seq_fin;
    logic [WIDTH-1:0] seq_hi;
    logic [WIDTH-1:0] seq_lo;

    alu_muldiv_seq #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .go     (seq_go),
        .is_div (selector == OP_DIV),
        .a      (Data1),
        .b      (Data2),
        .fin    (seq_fin),
        .hi     (seq_hi),
        .lo     (seq_lo)
    );

    // Single-cycle result; MUL/DIV codes fall into the default but are
    // never loaded from here.
    always_comb begin
        add_res = Data1 + Data2;
        sub_res = Data1 - Data2;
        alu_res = Data2;
        alu_ovf = 1'b0;
        case (selector)
            OP_AND: alu_res = Data1 & Data2;
            OP_OR:  alu_res = Data1 | Data2;
            OP_XOR: alu_res = Data1 ^ Data2;
            OP_NOR: alu_res = ~(Data1 | Data2);
            OP_SLT: alu_res = (Data1 < Data2) ? WIDTH'(1) : '0;
            OP_ADD: begin
                alu_res = add_res;
                alu_ovf = (Data1[MSB] == Data2[MSB]) && (add_res[MSB] != Data1[MSB]);
            end
            OP_SUB: begin
                alu_res = sub_res;
                alu_ovf = (Data1[MSB] != Data2[MSB]) && (sub_res[MSB] != Data1[MSB]);
            end
            default: alu_res = Data2;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        salida_d = salida_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        seq_go   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (is_iterative(selector)) begin
                        seq_go  = 1'b1;
                        state_d = (selector == OP_DIV) ? ST_DIV : ST_MUL;
                    end else begin
                        salida_d = alu_res;
                        zero_d   = (alu_res == '0);
                        ovf_d    = alu_ovf;
                        done_d   = 1'b1;
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                if (seq_fin) begin
                    hi_d     = seq_hi;
                    lo_d     = seq_lo;
                    salida_d = seq_lo;
                    zero_d   = (seq_lo == '0);
                    ovf_d    = 1'b0;
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            salida_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            salida_q <= salida_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    assign salida   = salida_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign zero     = zero_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_alu_multiciclo.sv
module tb_alu_multiciclo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start32 = 1'b0;
    logic [3:0]  sel32 = 4'd0;
    logic [31:0] a32 = '0, b32 = '0;
    logic [31:0] sal32, hi32, lo32;
    logic        busy32, done32, zero32, ovf32;

    logic        start8 = 1'b0;
    logic [3:0]  sel8 = 4'd0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [7:0]  sal8, hi8, lo8;
    logic        busy8, done8, zero8, ovf8;

    int checks = 0;
    int errors = 0;

    // Bench-side HI/LO state per instance (only MUL/DIV change it).
    logic [31:0] mhi32 = '0, mlo32 = '0, mhi8 = '0, mlo8 = '0;

    alu_multiciclo #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .selector(sel32),
        .Data1(a32), .Data2(b32), .salida(sal32), .hi(hi32), .lo(lo32),
        .busy(busy32), .done(done32), .zero(zero32), .overflow(ovf32)
    );

    alu_multiciclo #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .selector(sel8),
        .Data1(a8), .Data2(b8), .salida(sal8), .hi(hi8), .lo(lo8),
        .busy(busy8), .done(done8), .zero(zero8), .overflow(ovf8)
    );

    always #5 clk = ~clk;

    // Reference model from the arithmetic definition of each op.
    function automatic void model(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                                  input int w, input logic [31:0] hi_in, input logic [31:0] lo_in,
                                  output logic [31:0] s, output logic [31:0] h, output logic [31:0] l,
                                  output logic ov, output int lat);
        longint unsigned m, ua, ub, p, r;
        longint sa, sb, sr, lim;
        m   = (64'd1 << w) - 64'd1;
        ua  = {32'd0, a} & m;
        ub  = {32'd0, b} & m;
        lim = longint'(64'd1 << (w - 1));
        sa  = (ua >= 64'(lim)) ? longint'(ua) - 2 * lim : longint'(ua);
        sb  = (ub >= 64'(lim)) ? longint'(ub) - 2 * lim : longint'(ub);
        h = hi_in; l = lo_in; ov = 1'b0; lat = 0; r = 0;
        case (sel)
            4'b0000: r = ua & ub;
            4'b0001: r = ua | ub;
            4'b0101: r = ua ^ ub;
            4'b1100: r = ~(ua | ub) & m;
            4'b0111: r = (ua < ub) ? 64'd1 : 64'd0;
            4'b0010: begin
                sr = sa + sb; r = (ua + ub) & m;
                ov = (sr >= lim) || (sr < -lim);
            end
            4'b0110: begin
                sr = sa - sb; r = (ua - ub) & m;
                ov = (sr >= lim) || (sr < -lim);
            end
            4'b1000: begin
                p = ua * ub;
                h = 32'(p >> w); l = 32'(p & m); r = p & m; lat = w;
            end
            4'b1010: begin
                if (ub == 0) begin
                    h = 32'(ua); l = 32'(m); r = m; lat = 1;
                end else begin
                    h = 32'(ua % ub); l = 32'(ua / ub); r = ua / ub; lat = w;
                end
            end
            default: r = ub;
        endcase
        s = 32'(r);
    endfunction

    // Drive one request in the cycle before edge k, then wait (bounded) for
    // done. lat = edges after k until done (0 = done already at edge k),
    // -1 if done never came.
    task automatic do_op(input bit w8, input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] s, output logic [31:0] h,
                         output logic [31:0] l, output logic ov, output logic z,
                         output logic bsy0, output logic bsyd);
        logic dn;
        @(negedge clk);
        if (w8) begin start8 = 1'b1; sel8 = sel; a8 = a[7:0]; b8 = b[7:0]; end
        else begin start32 = 1'b1; sel32 = sel; a32 = a; b32 = b; end
        @(posedge clk); #1;
        start8 = 1'b0; start32 = 1'b0;
        // Scramble the live inputs: only the latched copies may matter now.
        a32 = $urandom; b32 = $urandom; a8 = 8'($urandom); b8 = 8'($urandom);
        bsy0 = w8 ? busy8 : busy32;
        lat = 0;
        dn = w8 ? done8 : done32;
        while (!dn && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            dn = w8 ? done8 : done32;
        end
        if (!dn) lat = -1;
        s    = w8 ? {24'd0, sal8} : sal32;
        h    = w8 ? {24'd0, hi8}  : hi32;
        l    = w8 ? {24'd0, lo8}  : lo32;
        ov   = w8 ? ovf8  : ovf32;
        z    = w8 ? zero8 : zero32;
        bsyd = w8 ? busy8 : busy32;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({sal32, hi32, lo32, busy32, done32, zero32, ovf32} !== '0) begin
            errors++; $display("FAIL reset32: got %h/%h/%h b%b d%b z%b o%b required all 0",
                               sal32, hi32, lo32, busy32, done32, zero32, ovf32);
        end
        checks++;
        if ({sal8, hi8, lo8, busy8, done8, zero8, ovf8} !== '0) begin
            errors++; $display("FAIL reset8: got %h/%h/%h b%b d%b z%b o%b required all 0",
                               sal8, hi8, lo8, busy8, done8, zero8, ovf8);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({busy32, done32, busy8, done8} !== 4'b0) begin
            errors++; $display("FAIL idle_after_reset: busy/done %b%b%b%b required 0000",
                               busy32, done32, busy8, done8);
        end
    endtask

    task automatic test_add_sub();
        int lat; logic [31:0] s, h, l; logic ov, z, b0, bd;
        do_op(0, 4'b0010, 32'h7FFFFFFF, 32'd1, lat, s, h, l, ov, z, b0, bd);
        checks++; if (lat !== 0) begin errors++; $display("FAIL add_latency: got %0d required 0", lat); end
        checks++; if (s !== 32'h80000000) begin errors++; $display("FAIL add_result: got %h required 80000000", s); end
        checks++; if (ov !== 1'b1) begin errors++; $display("FAIL add_overflow: got %b required 1", ov); end
        checks++; if ({h, l} !== {mhi32, mlo32}) begin errors++; $display("FAIL add_hilo: got %h/%h required %h/%h", h, l, mhi32, mlo32); end
        @(posedge clk); #1;
        checks++; if (done32 !== 1'b0) begin errors++; $display("FAIL done_pulse: got %b required 0", done32); end
        do_op(0, 4'b0110, 32'd5, 32'd5, lat, s, h, l, ov, z, b0, bd);
        checks++; if (s !== 32'd0) begin errors++; $display("FAIL sub_result: got %h required 0", s); end
        checks++; if (z !== 1'b1) begin errors++; $display("FAIL sub_zero: got %b required 1", z); end
        checks++; if (ov !== 1'b0) begin errors++; $display("FAIL sub_overflow: got %b required 0", ov); end
    endtask

    task automatic test_mul();
        int lat; logic [31:0] s, h, l; logic ov, z, b0, bd;
        do_op(0, 4'b1000, 32'd7, 32'd6, lat, s, h, l, ov, z, b0, bd);
        checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL mul_busy: got %b required 1", b0); end
        checks++; if (lat !== 32) begin errors++; $display("FAIL mul_latency: got %0d required 32", lat); end
        checks++; if ({h, l, s} !== {32'd0, 32'd42, 32'd42}) begin errors++; $display("FAIL mul_7x6: got hi %h lo %h salida %h required 0/2a/2a", h, l, s); end
        checks++; if (bd !== 1'b0) begin errors++; $display("FAIL mul_busy_at_done: got %b required 0", bd); end
        do_op(0, 4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, s, h, l, ov, z, b0, bd);
        checks++; if ({h, l} !== {32'hFFFFFFFE, 32'h00000001}) begin errors++; $display("FAIL mul_max: got %h/%h required fffffffe/00000001", h, l); end
        mhi32 = h; mlo32 = l;
    endtask

    task automatic test_div();
        int lat; logic [31:0] s, h, l; logic ov, z, b0, bd;
        do_op(0, 4'b1010, 32'd100, 32'd7, lat, s, h, l, ov, z, b0, bd);
        checks++; if (lat !== 32) begin errors++; $display("FAIL div_latency: got %0d required 32", lat); end
        checks++; if ({h, l, s} !== {32'd2, 32'd14, 32'd14}) begin errors++; $display("FAIL div_100_7: got hi %h lo %h salida %h required 2/e/e", h, l, s); end
        do_op(0, 4'b1010, 32'd5, 32'd0, lat, s, h, l, ov, z, b0, bd);
        checks++; if (lat !== 1) begin errors++; $display("FAIL div0_latency: got %0d required 1", lat); end
        checks++; if ({h, l, s} !== {32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF}) begin errors++; $display("FAIL div0_result: got hi %h lo %h salida %h required 5/ffffffff/ffffffff", h, l, s); end
        checks++; if (bd !== 1'b0) begin errors++; $display("FAIL div0_busy: got %b required 0", bd); end
        mhi32 = 32'd5; mlo32 = 32'hFFFFFFFF;
    endtask

    task automatic test_busy_ignore();
        int lat; logic [31:0] s, h, l; logic ov, z, b0, bd;
        @(negedge clk); start32 = 1'b1; sel32 = 4'b1000; a32 = 32'd3; b32 = 32'd3;
        @(posedge clk); #1; start32 = 1'b0;
        lat = 0;
        while (!done32 && lat < 100) begin
            @(negedge clk);
            if (lat == 9) begin start32 = 1'b1; sel32 = 4'b0000; a32 = 32'hF0F0; b32 = 32'hFF00; end
            else begin start32 = 1'b0; a32 = $urandom; b32 = $urandom; end
            @(posedge clk); #1;
            lat++;
        end
        start32 = 1'b0;
        checks++; if (lat !== 32) begin errors++; $display("FAIL ignore_latency: got %0d required 32", lat); end
        checks++; if ({hi32, lo32, sal32} !== {32'd0, 32'd9, 32'd9}) begin errors++; $display("FAIL ignore_mul: got hi %h lo %h salida %h required 0/9/9", hi32, lo32, sal32); end
        do_op(0, 4'b0000, 32'hF0F0, 32'hFF00, lat, s, h, l, ov, z, b0, bd);
        checks++; if (s !== 32'hF000) begin errors++; $display("FAIL and_result: got %h required f000", s); end
        checks++; if ({h, l} !== {32'd0, 32'd9}) begin errors++; $display("FAIL and_hilo: got %h/%h required 0/9", h, l); end
        mhi32 = 32'd0; mlo32 = 32'd9;
    endtask

    task automatic test_reset_abort();
        int lat; logic [31:0] s, h, l; logic ov, z, b0, bd;
        bit seen;
        @(negedge clk); start32 = 1'b1; sel32 = 4'b1010; a32 = 32'd1000; b32 = 32'd10;
        @(posedge clk); #1; start32 = 1'b0;
        repeat (15) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({sal32, hi32, lo32, busy32, done32, zero32, ovf32} !== '0) begin
            errors++; $display("FAIL abort_reset: got %h/%h/%h b%b d%b z%b o%b required all 0",
                               sal32, hi32, lo32, busy32, done32, zero32, ovf32);
        end
        mhi32 = '0; mlo32 = '0; mhi8 = '0; mlo8 = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (done32 || busy32) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_done: got activity %b required 0", seen); end
        do_op(0, 4'b0010, 32'd2, 32'd3, lat, s, h, l, ov, z, b0, bd);
        checks++; if ({s, h, l} !== {32'd5, 32'd0, 32'd0}) begin errors++; $display("FAIL abort_then_add: got %h/%h/%h required 5/0/0", s, h, l); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] s, h, l; logic ov, z, b0, bd;
        do_op(0, 4'b1000, 32'd11, 32'd13, lat, s, h, l, ov, z, b0, bd);
        checks++; if (bd !== 1'b0 || l !== 32'd143) begin errors++; $display("FAIL b2b_mul: got busy %b lo %h required 0/8f", bd, l); end
        // Driven in the done cycle: accepted at the very next edge.
        do_op(0, 4'b0001, 32'h0F, 32'hF0, lat, s, h, l, ov, z, b0, bd);
        checks++; if (lat !== 0 || s !== 32'hFF) begin errors++; $display("FAIL b2b_or: got lat %0d salida %h required 0/ff", lat, s); end
        do_op(0, 4'b0111, 32'd3, 32'd9, lat, s, h, l, ov, z, b0, bd);
        checks++; if (lat !== 0 || s !== 32'd1) begin errors++; $display("FAIL b2b_slt: got lat %0d salida %h required 0/1", lat, s); end
        mhi32 = 32'd0; mlo32 = 32'd143;
    endtask

    task automatic test_random(input bit w8, input int n);
        logic [3:0] ops [13] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd5, 4'd12, 4'd8, 4'd10, 4'd3, 4'd4, 4'd9, 4'd15};
        int w, lat, elat;
        logic [31:0] a, b, s, h, l, es, eh, el;
        logic ov, z, b0, bd, eov;
        w = w8 ? 8 : 32;
        for (int i = 0; i < n; i++) begin
            logic [3:0] sel;
            sel = ops[$urandom_range(0, 12)];
            case ($urandom_range(0, 7))
                0: a = '0;
                1: a = '1;
                2: a = 32'h1 << (w - 1);
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: b = '0;
                1: b = '1;
                2: b = (32'h1 << (w - 1)) - 1;
                default: b = $urandom;
            endcase
            model(sel, a, b, w, w8 ? mhi8 : mhi32, w8 ? mlo8 : mlo32, es, eh, el, eov, elat);
            do_op(w8, sel, a, b, lat, s, h, l, ov, z, b0, bd);
            checks++;
            if (lat !== elat || s !== es || h !== eh || l !== el || ov !== eov || z !== (es == 0)) begin
                errors++;
                $display("FAIL rand_w%0d op %b a %h b %h: got lat %0d s %h hi %h lo %h ov %b z %b required lat %0d s %h hi %h lo %h ov %b z %b",
                         w, sel, a, b, lat, s, h, l, ov, z, elat, es, eh, el, eov, (es == 0));
            end
            if (w8) begin mhi8 = eh; mlo8 = el; end
            else begin mhi32 = eh; mlo32 = el; end
        end
    endtask

    task automatic test_width8();
        int lat; logic [31:0] s, h, l; logic ov, z, b0, bd;
        do_op(1, 4'b1000, 32'hFF, 32'h02, lat, s, h, l, ov, z, b0, bd);
        checks++; if (lat !== 8) begin errors++; $display("FAIL w8_mul_latency: got %0d required 8", lat); end
        checks++; if ({h, l} !== {32'h01, 32'hFE}) begin errors++; $display("FAIL w8_mul: got %h/%h required 01/fe", h, l); end
        do_op(1, 4'b0011, 32'h12, 32'hAB, lat, s, h, l, ov, z, b0, bd);
        checks++; if (s !== 32'hAB || {h, l} !== {32'h01, 32'hFE}) begin errors++; $display("FAIL w8_pass: got salida %h hi %h lo %h required ab/01/fe", s, h, l); end
        mhi8 = 32'h01; mlo8 = 32'hFE;
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_mul();
        test_div();
        test_busy_ignore();
        test_back_to_back();
        test_random(0, 50);
        test_reset_abort();
        test_width8();
        test_random(1, 40);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_multiciclo.md
Name: alu_multiciclo

Overview:
Parametrised multi-cycle successor to the single-cycle MIPS ALU.
- Logic, add/sub and compare ops complete in 1 clock.
- MUL (shift-add) and DIV (restoring) run iteratively over WIDTH clocks instead of as combinational `*` and `/`.
- Full 2*WIDTH product and remainder are kept in HI/LO registers for mfhi/mflo.
- Sits in the EX stage; the control unit stalls the pipeline while `busy` is high.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only when busy=0
- selector  in  4  op code, same encoding as the existing ALU
- Data1  in  WIDTH  operand A (dividend / multiplicand)
- Data2  in  WIDTH  operand B (divisor / multiplier)
- salida  out  WIDTH  registered result; held until the next done
- hi  out  WIDTH  MUL: product[2W-1:W]; DIV: remainder
- lo  out  WIDTH  MUL: product[W-1:0]; DIV: quotient
- busy  out  1  high while an iterative op is in progress
- done  out  1  one-cycle pulse when salida (and hi/lo for MUL/DIV) update
- zero  out  1  registered, (salida==0), updated with done
- overflow  out  1  registered signed overflow for ADD/SUB; 0 for all other ops

Behaviour:
- Reset (async, rst_n=0): salida, hi, lo = 0; busy, done, zero, overflow = 0; FSM -> IDLE; counter = 0. Takes effect immediately, including mid-iteration. The aborted op produces no done.
- Encodings (unsigned unless stated):
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (unsigned, result 1/0)
  - 0101 XOR, 1100 NOR, 1000 MUL, 1010 DIV
  - all other codes: pass Data2
- FSM states: IDLE, MUL, DIV.
- IDLE, start=1 with a single-cycle op, accepted at edge k:
  - at edge k, salida, zero and overflow load and done=1;
  - done returns to 0 at edge k+1 unless a new op completes there;
  - hi/lo unchanged.
- IDLE, start=1 with MUL/DIV, accepted at edge k:
  - operands are latched; busy=1 at edge k; counter = 0.
  - One iteration per edge, k+1 .. k+WIDTH.
  - At edge k+WIDTH: hi, lo, salida (= lo), zero load; busy=0; done=1; FSM -> IDLE.
  - Latency is exactly WIDTH clocks.
- MUL: unsigned 2W product built as accumulator {hi,lo} with shift-right add. No overflow reported; overflow=0.
- DIV: restoring, one quotient bit per cycle.
  - Divisor = 0: no iteration. Result at edge k+1 with lo = all ones, hi = Data1, salida = all ones, busy=0 at k+1.
- start while busy=1: ignored. Operands and selector may change freely during busy; the latched copies are used.
- Back-to-back: in the cycle done=1, busy is already 0, so a start in that cycle is accepted at the next edge.
- Arithmetic: ADD/SUB wrap modulo 2^WIDTH.
  - ADD overflow = (A[msb]==B[msb]) && (R[msb]!=A[msb]).
  - SUB overflow = (A[msb]!=B[msb]) && (R[msb]!=A[msb]).
- hi/lo change only on MUL/DIV completion, never on single-cycle ops.

Decomposition:
- Shared package alu_pkg:
  - localparam op codes: OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_XOR, OP_NOR, OP_MUL, OP_DIV;
  - FSM state enum (ST_IDLE, ST_MUL, ST_DIV).
  - Used also by the control unit.
- Sub-module alu_muldiv_seq holds the iterative shift-add/restoring datapath, counter and operand latches.
  - Interface: go, is_div, a, b -> fin, hi, lo.
  - Top level holds the combinational single-cycle ops, output registers and FSM.

Test Plan:
1. WIDTH=32, ADD 0x7FFFFFFF + 1 -> salida 0x80000000, overflow=1, done 1 cycle after start; then SUB 5-5 -> salida 0, zero=1.
2. MUL 7*6 -> busy for 32 cycles; at done: lo=42, hi=0, salida=42. MUL 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
3. DIV 100/7 -> after 32 cycles lo=14, hi=2, salida=14. DIV 5/0 -> next cycle lo=0xFFFFFFFF, hi=5, done=1.
4. MUL 3*3 started, start with AND pulsed at cycle 10 -> ignored; lo=9 at cycle 32; then AND 0xF0F0&0xFF00 -> 0xF000, hi/lo remain 0/9.
5. DIV 1000/10 started, rst_n low at cycle 15 -> all outputs 0 immediately, no done. After release, ADD 2+3 -> salida=5.
6. WIDTH=8 instance: MUL 0xFF*0x02 -> hi=0x01, lo=0xFE after 8 cycles. Selector 0011 with Data2=0xAB -> salida=0xAB.
